// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period sequencer.
// Period enum, video guard words and preamble control codes.
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_e;

  localparam logic [9:0] GUARD_WORD_BR = 10'b1011001100;
  localparam logic [9:0] GUARD_WORD_G  = 10'b0100110011;

  localparam logic [1:0] CTL_IDLE      = 2'b00;
  localparam logic [1:0] PRE_CTL_GREEN = 2'b01;
  localparam logic [1:0] PRE_CTL_RED   = 2'b00;

endpackage

// File: rtl/hdmi_period_sequencer_if.sv
// Video timing in, encoder-facing controls out.
// master drives the timing/pixels, slave is the sequencer.
interface hdmi_period_sequencer_if;

  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;

  logic [7:0] red_out;
  logic [7:0] green_out;
  logic [7:0] blue_out;
  logic       ve_out;
  logic [1:0] ctrl_blue_out;
  logic [1:0] ctrl_green_out;
  logic [1:0] ctrl_red_out;
  logic       guard_out;
  logic       short_blank_out;

  modport master (
    output de_in, hsync_in, vsync_in,
    output red_in, green_in, blue_in,
    input  red_out, green_out, blue_out,
    input  ve_out, guard_out, short_blank_out,
    input  ctrl_blue_out, ctrl_green_out, ctrl_red_out
  );

  modport slave (
    input  de_in, hsync_in, vsync_in,
    input  red_in, green_in, blue_in,
    output red_out, green_out, blue_out,
    output ve_out, guard_out, short_blank_out,
    output ctrl_blue_out, ctrl_green_out, ctrl_red_out
  );

endinterface

// File: rtl/hdmi_period_sequencer_pipe_delay.sv
// Fixed-depth shift register with async clear.
// Carries the {de, hs, vs, r, g, b} word through the sequencer.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_period_sequencer.sv
// Delays the video stream by D+1 cycles and frames each active
// region with a control-period preamble and video guard band.
module hdmi_period_sequencer
  import hdmi_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int DVI_MODE     = 0
) (
  input  logic clk_in,
  input  logic rst_in,
  hdmi_period_sequencer_if.slave bus
);

  localparam int D   = PREAMBLE_LEN + GUARD_LEN;
  localparam int CW  = $clog2(D + 1);
  localparam int W   = 27;
  localparam bit DVI = (DVI_MODE != 0);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t D_C = cnt_t'(D);
  localparam cnt_t G_C = cnt_t'(GUARD_LEN);
  localparam cnt_t ONE = cnt_t'(1);

  logic [W-1:0]   in_word;
  logic [W-1:0]   tap;
  logic [W-2:0]   out_q;
  logic           tap_de;
  logic           rise;

  period_e        state;
  period_e        state_nxt;
  cnt_t           cnt;
  cnt_t           cnt_nxt;
  cnt_t           gap;
  cnt_t           gap_nxt;
  logic           de_q;
  logic           short_q;
  logic           short_nxt;

  logic           ve;
  logic           guard;
  logic [1:0]     ctl_g;
  logic [1:0]     ctl_r;

  assign in_word = {bus.de_in, bus.hsync_in, bus.vsync_in,
                    bus.red_in, bus.green_in, bus.blue_in};

  pipe_delay #(
    .WIDTH (W),
    .DEPTH (D)
  ) u_delay (
    .clk (clk_in),
    .rst (rst_in),
    .d   (in_word),
    .q   (tap)
  );

  assign tap_de = tap[W-1];

  // de_q resets high so a de_in already asserted at release is no edge
  assign rise = bus.de_in & ~de_q & ~DVI;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= CTRL;
      cnt     <= '0;
      gap     <= D_C;
      de_q    <= 1'b1;
      short_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap     <= gap_nxt;
      de_q    <= bus.de_in;
      short_q <= short_nxt;
      out_q   <= tap[W-2:0];
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    short_nxt = short_q;
    state_nxt = CTRL;
    ve        = 1'b0;
    guard     = 1'b0;
    ctl_g     = CTL_IDLE;
    ctl_r     = CTL_IDLE;

    if (rise) begin
      cnt_nxt = D_C;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - ONE;
    end

    // gap counts blank input cycles since the last active pixel
    if (bus.de_in) begin
      gap_nxt = '0;
    end else if (gap != D_C) begin
      gap_nxt = gap + ONE;
    end

    if (rise && (gap < D_C)) begin
      short_nxt = 1'b1;
    end

    // delayed video always wins; the counter only fills the blank
    if (tap_de) begin
      state_nxt = VIDEO;
    end else if (cnt_nxt > G_C) begin
      state_nxt = PREAMBLE;
    end else if (cnt_nxt != '0) begin
      state_nxt = GUARD;
    end

    unique case (state)
      PREAMBLE: begin
        ctl_g = PRE_CTL_GREEN;
        ctl_r = PRE_CTL_RED;
      end
      GUARD:    guard = 1'b1;
      VIDEO:    ve = 1'b1;
      default:  ;
    endcase
  end

  assign bus.red_out         = out_q[23:16];
  assign bus.green_out       = out_q[15:8];
  assign bus.blue_out        = out_q[7:0];
  assign bus.ctrl_blue_out   = {out_q[24], out_q[25]};
  assign bus.ctrl_green_out  = ctl_g;
  assign bus.ctrl_red_out    = ctl_r;
  assign bus.ve_out          = ve;
  assign bus.guard_out       = guard;
  assign bus.short_blank_out = short_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Scoreboard bench: HDMI and DVI instances fed the same stream,
// expected per-cycle outputs queued by the driver, checked by a monitor.
module tb_hdmi_period_sequencer;

  localparam int P   = 8;
  localparam int G   = 2;
  localparam int D   = P + G;
  localparam int LAT = D + 1;
  localparam int N   = 2048;

  typedef struct packed {
    logic        ve;
    logic        guard;
    logic [1:0]  cb;
    logic [1:0]  cg;
    logic [1:0]  cr;
    logic [23:0] pix;
    logic        sb;
  } obs_t;

  typedef struct packed {
    logic [31:0] cyc;
    obs_t        h;
    obs_t        d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_period_sequencer_if hb ();
  hdmi_period_sequencer_if dv ();

  hdmi_period_sequencer #(
    .PREAMBLE_LEN (P),
    .GUARD_LEN    (G),
    .DVI_MODE     (0)
  ) dut_hdmi (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (hb.slave)
  );

  hdmi_period_sequencer #(
    .PREAMBLE_LEN (P),
    .GUARD_LEN    (G),
    .DVI_MODE     (1)
  ) dut_dvi (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (dv.slave)
  );

  obs_t ho;
  obs_t dobs;
  assign ho = {hb.ve_out, hb.guard_out, hb.ctrl_blue_out,
               hb.ctrl_green_out, hb.ctrl_red_out,
               hb.red_out, hb.green_out, hb.blue_out,
               hb.short_blank_out};
  assign dobs = {dv.ve_out, dv.guard_out, dv.ctrl_blue_out,
                 dv.ctrl_green_out, dv.ctrl_red_out,
                 dv.red_out, dv.green_out, dv.blue_out,
                 dv.short_blank_out};

  bit          s_de  [N];
  bit          s_hs  [N];
  bit          s_vs  [N];
  bit          s_rst [N];
  logic [23:0] s_pix [N];
  int          n_cyc = 0;
  int          ramp  = 0;

  ent_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int len, input bit de, input bit rs);
    logic [7:0] v;
    logic [7:0] n8;
    for (int i = 0; i < len; i++) begin
      n8 = n_cyc[7:0];
      s_de[n_cyc]  = de;
      s_rst[n_cyc] = rs;
      s_hs[n_cyc]  = (n_cyc % 7) == 0;
      s_vs[n_cyc]  = (n_cyc % 13) < 2;
      if (de) begin
        v = ramp[7:0];
        s_pix[n_cyc] = {v, v + 8'h40, ~v};
        ramp++;
      end else begin
        s_pix[n_cyc] = {8'hA5, n8, 8'h3C};
      end
      n_cyc++;
    end
  endtask

  function automatic int last_rel(input int c);
    int i;
    i = c;
    while (i > 0 && !s_rst[i-1]) i--;
    return i;
  endfunction

  function automatic bit is_rise(input int t, input int r);
    return (t - 1 >= r) && s_de[t] && !s_de[t-1];
  endfunction

  function automatic int gap_before(input int t, input int r);
    int g;
    g = 0;
    for (int i = t - 1; i >= r; i--) begin
      if (s_de[i]) return g;
      g++;
    end
    return 1000;
  endfunction

  function automatic obs_t exp_obs(input int c, input bit dvi);
    obs_t o;
    int   r, src, k, g, gd, pr, t0;
    o = '0;
    if (s_rst[c]) return o;
    r   = last_rel(c);
    src = c - LAT;
    if (src >= r) begin
      o.pix = s_pix[src];
      o.cb  = {s_vs[src], s_hs[src]};
      o.ve  = s_de[src];
    end
    if (dvi) return o;
    for (int t = r + 1; t < c; t++) begin
      if (is_rise(t, r) && gap_before(t, r) < D) o.sb = 1'b1;
    end
    if (!o.ve) begin
      t0 = (c - D > r + 1) ? c - D : r + 1;
      for (int t = t0; t < c; t++) begin
        if (is_rise(t, r)) begin
          k  = t + LAT - c;
          g  = gap_before(t, r);
          gd = (g < G) ? g : G;
          pr = ((g - gd) < P) ? (g - gd) : P;
          if (k <= gd) o.guard = 1'b1;
          else if (k <= gd + pr) o.cg = 2'b01;
          break;
        end
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input int cyc,
                       input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h", name, cyc, act, want);
    end
  endtask

  task automatic drive(input int c);
    rst = s_rst[c];
    hb.de_in = s_de[c];  dv.de_in = s_de[c];
    hb.hsync_in = s_hs[c]; dv.hsync_in = s_hs[c];
    hb.vsync_in = s_vs[c]; dv.vsync_in = s_vs[c];
    {hb.red_in, hb.green_in, hb.blue_in} = s_pix[c];
    {dv.red_in, dv.green_in, dv.blue_in} = s_pix[c];
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent_t e;
      e = exp_q.pop_front();
      check("hdmi", int'(e.cyc), ho, e.h);
      check("dvi", int'(e.cyc), dobs, e.d);
    end
  end

  initial begin
    hb.de_in = 1'b0; hb.hsync_in = 1'b0; hb.vsync_in = 1'b0;
    hb.red_in = '0; hb.green_in = '0; hb.blue_in = '0;
    dv.de_in = 1'b0; dv.hsync_in = 1'b0; dv.vsync_in = 1'b0;
    dv.red_in = '0; dv.green_in = '0; dv.blue_in = '0;

    add(3, 1'b0, 1'b1);
    add(100, 1'b0, 1'b0);
    add(640, 1'b1, 1'b0);
    add(5, 1'b0, 1'b0);
    add(20, 1'b1, 1'b0);
    add(1, 1'b0, 1'b0);
    add(10, 1'b1, 1'b0);
    add(40, 1'b0, 1'b0);
    add(100, 1'b0, 1'b0);
    add(4, 1'b1, 1'b0);
    add(2, 1'b1, 1'b1);
    add(194, 1'b1, 1'b0);
    add(60, 1'b0, 1'b0);
    add(30, 1'b1, 1'b0);
    add(40, 1'b0, 1'b0);

    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      if (c > 0 && s_rst[c] && !s_rst[c-1]) begin
        #1;
        check("async_rst_hdmi", c, ho, '0);
        check("async_rst_dvi", c, dobs, '0);
      end
      exp_q.push_back('{cyc: c, h: exp_obs(c, 1'b0), d: exp_obs(c, 1'b1)});
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
